// File: rtl/char_text_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : char_text_buffer
//  Description : 16x16 text-mode character store for the VGA char-draw path.
//                Looks up the character at char_xy and returns a registered
//                font ROM address {char_code, char_line}. A valid/ready byte
//                port writes characters at a hardware cursor and interprets
//                LF, CR, BS and FF. Reset and FF fill the store with FILL_CHAR.
//  Ports       : pclk, rst            - pixel clock, sync active-high reset
//                char_xy, char_line   - lookup cell {col,row} and glyph row
//                addr_out             - font ROM address, 1-clk latency
//                wr_valid, wr_data,
//                wr_ready             - byte-stream write handshake
//                cursor_x, cursor_y   - current write position
//                busy                 - high while the clear pass runs
//  Revision    : 1.0 - initial release
// ============================================================================
module char_text_buffer #(
  parameter logic [6:0] FILL_CHAR      = 7'h20,
  parameter bit         CLEAR_ON_RESET = 1'b1
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [7:0]  char_xy,
  input  logic [3:0]  char_line,
  output logic [10:0] addr_out,
  input  logic        wr_valid,
  input  logic [7:0]  wr_data,
  output logic        wr_ready,
  output logic [3:0]  cursor_x,
  output logic [3:0]  cursor_y,
  output logic        busy
);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  localparam logic [7:0] C_BYTE_LF = 8'h0A;
  localparam logic [7:0] C_BYTE_CR = 8'h0D;
  localparam logic [7:0] C_BYTE_BS = 8'h08;
  localparam logic [7:0] C_BYTE_FF = 8'h0C;

  state_t      state_q, state_d;
  logic [7:0]  clr_cnt_q, clr_cnt_d;
  logic [3:0]  cursor_x_q, cursor_x_d;
  logic [3:0]  cursor_y_q, cursor_y_d;
  logic [10:0] addr_q, addr_d;

  logic [6:0]  mem [256];
  logic        mem_we;
  logic [7:0]  mem_waddr;
  logic [6:0]  mem_wdata;
  logic        accept;

  // Handshake and status come straight from the state register.
  assign wr_ready = (state_q == ST_IDLE);
  assign busy     = (state_q == ST_CLEAR);
  assign accept   = wr_valid & wr_ready;

  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    cursor_x_d = cursor_x_q;
    cursor_y_d = cursor_y_q;
    mem_we     = 1'b0;
    mem_waddr  = 8'h00;
    mem_wdata  = 7'h00;
    addr_d     = {mem[char_xy], char_line};

    case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_cnt_q;
        mem_wdata = FILL_CHAR;
        clr_cnt_d = clr_cnt_q + 8'd1;   // wraps to 0 after the last cell
        if (clr_cnt_q == 8'hFF) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (accept) begin
          if (wr_data >= 8'h20 && wr_data <= 8'h7E) begin
            mem_we     = 1'b1;
            mem_waddr  = {cursor_x_q, cursor_y_q};
            mem_wdata  = wr_data[6:0];
            cursor_x_d = cursor_x_q + 4'd1;
            if (cursor_x_q == 4'hF) begin
              cursor_y_d = cursor_y_q + 4'd1;  // no scroll: row wraps
            end
          end else if (wr_data == C_BYTE_LF) begin
            cursor_x_d = 4'd0;
            cursor_y_d = cursor_y_q + 4'd1;
          end else if (wr_data == C_BYTE_CR) begin
            cursor_x_d = 4'd0;
          end else if (wr_data == C_BYTE_BS) begin
            if (cursor_x_q != 4'd0) begin
              cursor_x_d = cursor_x_q - 4'd1;
            end
          end else if (wr_data == C_BYTE_FF) begin
            cursor_x_d = 4'd0;
            cursor_y_d = 4'd0;
            state_d    = ST_CLEAR;
          end
          // anything else is consumed without effect
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q    <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
      clr_cnt_q  <= 8'h00;
      cursor_x_q <= 4'd0;
      cursor_y_q <= 4'd0;
      addr_q     <= 11'h000;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      cursor_x_q <= cursor_x_d;
      cursor_y_q <= cursor_y_d;
      addr_q     <= addr_d;
    end
  end

  // Storage is not reset. The lookup above samples the pre-write contents,
  // which gives read-first behaviour on a same-cell collision.
  always_ff @(posedge pclk) begin
    if (mem_we && !rst) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign addr_out = addr_q;
  assign cursor_x = cursor_x_q;
  assign cursor_y = cursor_y_q;

endmodule
`default_nettype wire
